// File: rtl/pong_ball_tracker.sv
// pong_ball_tracker: single-ball engine for the LED tennis game.
// Steps a one-hot ball across an N_LEDS bar at a programmable tick rate,
// accepts serves and in-window hits, and reports misses off either end.
module pong_ball_tracker #(
  parameter int unsigned N_LEDS   = 16,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned HIT_WIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serve_left,
  input  logic              serve_right,
  input  logic              hit_left,
  input  logic              hit_right,
  output logic [N_LEDS-1:0] ball,
  output logic              in_play,
  output logic              miss_left,
  output logic              miss_right,
  output logic [7:0]        rally_count
);

  localparam int unsigned PW = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]     POS_MAX = PW'(N_LEDS - 1);
  localparam logic [PW-1:0]     WIN_L   = PW'(HIT_WIN - 1);
  localparam logic [PW-1:0]     WIN_R   = PW'(N_LEDS - HIT_WIN);
  localparam logic [CW-1:0]     CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [N_LEDS-1:0] ONE     = N_LEDS'(1);
  localparam logic [7:0]        RALLY_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2
  } state_t;

  state_t              state_q, state_d;
  state_t              dir_c;
  logic [PW-1:0]       pos_q, pos_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_LEDS-1:0]   ball_q, ball_d;
  logic                in_play_q, in_play_d;
  logic                miss_l_q, miss_l_d;
  logic                miss_r_q, miss_r_d;
  logic [7:0]          rally_q, rally_d;
  logic                tick_c;
  logic                hit_ok_c;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      cnt_q     <= '0;
      ball_q    <= '0;
      in_play_q <= 1'b0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
      rally_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      ball_q    <= ball_d;
      in_play_q <= in_play_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
      rally_q   <= rally_d;
    end
  end

  // Next state: serve from idle; while moving, apply hit reversal then tick step
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    in_play_d = in_play_q;
    miss_l_d  = 1'b0;
    miss_r_d  = 1'b0;
    rally_d   = rally_q;
    tick_c    = 1'b0;
    hit_ok_c  = 1'b0;
    dir_c     = state_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (serve_left != serve_right) begin
          rally_d   = '0;
          in_play_d = 1'b1;
          if (serve_left) begin
            pos_d   = '0;
            state_d = MOVE_R;
          end else begin
            pos_d   = POS_MAX;
            state_d = MOVE_L;
          end
        end
      end

      MOVE_R, MOVE_L: begin
        tick_c = (cnt_q == CNT_MAX);
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);

        hit_ok_c = ((state_q == MOVE_R) && hit_right && (pos_q >= WIN_R)) ||
                   ((state_q == MOVE_L) && hit_left  && (pos_q <= WIN_L));

        // Reversal is resolved before the step so a same-cycle tick moves the new way
        if (hit_ok_c) begin
          dir_c = (state_q == MOVE_R) ? MOVE_L : MOVE_R;
          if (rally_q != RALLY_MAX) begin
            rally_d = rally_q + 8'd1;
          end
        end
        state_d = dir_c;

        if (tick_c) begin
          if (dir_c == MOVE_R) begin
            if (pos_q == POS_MAX) begin
              miss_r_d = 1'b1;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              miss_l_d = 1'b1;
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end

        if (miss_l_d || miss_r_d) begin
          state_d   = IDLE;
          in_play_d = 1'b0;
          pos_d     = '0;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        in_play_d = 1'b0;
        pos_d     = '0;
        cnt_d     = '0;
      end
    endcase

    ball_d = in_play_d ? (ONE << pos_d) : '0;
  end

  assign ball        = ball_q;
  assign in_play     = in_play_q;
  assign miss_left   = miss_l_q;
  assign miss_right  = miss_r_q;
  assign rally_count = rally_q;

endmodule

// File: doc/pong_ball_tracker.md
# pong_ball_tracker

Parametrised ball engine for the LED tennis game. It holds one ball on an N_LEDS-wide one-hot LED bar and steps it at a programmable tick rate. It accepts serves and debounced hit pulses from both players, reverses the ball on valid hits inside a hit window, and flags misses. It sits between the button debouncers and the LED/score logic.

## Interface
- N_LEDS, 16: LED bar width; index 0 is the left player's end, N_LEDS-1 the right player's end. Must be ≥2.
- TICK_DIV, 25_000_000: clk cycles per ball step; ≥1.
- HIT_WIN, 2: number of LEDs at each end where a hit is accepted; 1..N_LEDS/2.
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- serve_left, input, 1: one-cycle debounced pulse; left player serves.
- serve_right, input, 1: one-cycle debounced pulse; right player serves.
- hit_left, input, 1: one-cycle debounced pulse; left player swings.
- hit_right, input, 1: one-cycle debounced pulse; right player swings.
- ball, output, N_LEDS: one-hot ball position, all-zero when idle; registered.
- in_play, output, 1: high while a rally is active.
- miss_left, output, 1: one-cycle pulse; ball left the bar past index 0.
- miss_right, output, 1: one-cycle pulse; ball left the bar past index N_LEDS-1.
- rally_count, output, 8: hits accepted since the last serve; saturates at 255.

## Operation
- The FSM has three states: IDLE, MOVE_R (index increasing), MOVE_L (index decreasing).
- Reset puts the block in IDLE and clears ball, in_play, miss_left, miss_right, rally_count and the tick counter. This takes effect immediately and also applies mid-rally.
- IDLE behaviour:
  - serve_left alone: pos=0, MOVE_R.
  - serve_right alone: pos=N_LEDS-1, MOVE_L.
  - Both serves in the same cycle: both ignored.
  - A serve clears the tick counter and rally_count.
  - Hits are ignored in IDLE.
- The tick counter counts 0..TICK_DIV-1 while moving. A tick is asserted in the cycle the counter equals TICK_DIV-1, and the counter then wraps to 0.
- Accepted hits:
  - hit_left is accepted only in MOVE_L with pos ≤ HIT_WIN-1.
  - hit_right is accepted only in MOVE_R with pos ≥ N_LEDS-HIT_WIN.
  - An accepted hit reverses the state, increments rally_count (saturating), and does not touch the tick counter.
  - Hits in the wrong direction or outside the window are ignored, with no penalty.
- On a tick in MOVE_R:
  - pos<N_LEDS-1: pos+1.
  - pos=N_LEDS-1: miss_right pulses, ball goes to 0, in_play goes low, state goes to IDLE.
- MOVE_L on a tick mirrors this: pos-1, or miss_left at pos=0.
- Accepted hit and tick in the same cycle: the reversal applies first and the step is taken in the new direction. Example: pos 0 in MOVE_L with hit_left and tick gives pos 1, MOVE_R, no miss.
- Serves while moving are ignored.
- pos width is $clog2(N_LEDS). The ball decode is a registered shift of 1 by pos, so no out-of-range value can occur.

## Timing
- A serve sampled on edge k gives ball and in_play valid after edge k.
- The first step occurs exactly TICK_DIV cycles after the serve edge, and every later step is TICK_DIV cycles after the previous one.
- A hit takes effect on the edge that samples it; rally_count updates on that same edge.
- The miss pulse is high for exactly one cycle, coincident with ball going to 0 and in_play going low.
- A serve is accepted on the cycle immediately after a miss.

## Test plan
Configuration for all scenarios: N_LEDS=16, TICK_DIV=4, HIT_WIN=2.
- Reset → ball=0x0000, in_play=0, rally_count=0, both misses low. Asserting rst mid-rally at pos 7 clears everything asynchronously, before the next clock edge.
- serve_left, no hits → ball=0x0001, then 0x0002 four cycles later, …, 0x8000 after 60 cycles. On the next tick, miss_right pulses for one cycle and ball=0x0000.
- serve_left, then hit_right at pos 14 → reversal: next tick gives ball=0x2000 and rally_count=1. Then hit_left at pos 1 → rally_count=2, and the ball moves right.
- hit_right at pos 10, or hit_left while in MOVE_R → ignored. Position sequence and rally_count are unchanged.
- hit_right coincident with the tick at pos 15 → ball=0x4000, no miss_right, rally_count increments.
- serve_left and serve_right in the same cycle while IDLE → stays idle. serve_right mid-rally → ignored. 300 accepted hits → rally_count holds at 255.
